// File: rtl/prs_density_meter_if.sv
// -----------------------------------------------------------------------------
// prs_density_meter_if
//   Sample-stream and result bundle for prs_density_meter.
//   master : drives en / clr / bit_in, observes the window results.
//   slave  : the meter itself; consumes samples, drives the results.
//   Signals:
//     en         sample strobe, bit_in consumed only when high
//     clr        synchronous soft clear (same effect as reset)
//     bit_in     incoming pseudo-random bit
//     sum_out    ones count over the last N accepted samples
//     sum_valid  high once the window holds N samples
//     frame_done one-cycle pulse every N accepted samples
//     frame_sum  sum_out snapshot taken with each frame_done
// -----------------------------------------------------------------------------
interface prs_density_meter_if #(
  parameter int WIN_LOG2 = 5
);
  logic                en;
  logic                clr;
  logic                bit_in;
  logic [WIN_LOG2:0]   sum_out;
  logic                sum_valid;
  logic                frame_done;
  logic [WIN_LOG2:0]   frame_sum;

  modport master (
    output en, clr, bit_in,
    input  sum_out, sum_valid, frame_done, frame_sum
  );

  modport slave (
    input  en, clr, bit_in,
    output sum_out, sum_valid, frame_done, frame_sum
  );
endinterface

// File: rtl/prs_density_meter.sv
// -----------------------------------------------------------------------------
// prs_density_meter
//   Sliding-window ones counter for a pseudo-random bitstream. Keeps the last
//   N = 2**WIN_LOG2 accepted bits and a running count of ones among them,
//   plus a frame counter that pulses frame_done (and snapshots the count into
//   frame_sum) every N accepted samples.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset (priority over everything)
//     bus  prs_density_meter_if.slave: en, clr, bit_in in;
//          sum_out, sum_valid, frame_done, frame_sum out
// -----------------------------------------------------------------------------
module prs_density_meter #(
  parameter int WIN_LOG2 = 5  // legal 2..8
) (
  input  logic                    clk,
  input  logic                    rst,
  prs_density_meter_if.slave      bus
);

  localparam int N     = 1 << WIN_LOG2;
  localparam int SUM_W = WIN_LOG2 + 1;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;  // N-1

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [N-1:0]        r_hist;
  logic [SUM_W-1:0]    r_sum;
  logic [WIN_LOG2-1:0] r_cnt;
  logic                r_valid;
  logic                r_frame_done;
  logic [SUM_W-1:0]    r_frame_sum;

  logic                w_oldest;
  logic [SUM_W-1:0]    w_sum_next;
  logic                w_wrap;
  logic                w_clear;

  assign w_clear = rst | bus.clr;

  // The bit leaving the window only counts once the window is full; before
  // that the history tail is still a reset zero, but gating on RUN makes
  // the intent explicit.
  assign w_oldest   = (r_state == RUN) ? r_hist[N-1] : 1'b0;
  // Range stays within 0..N: a 1 is only added while fewer than N ones are
  // held, and a 1 is only removed if it was previously counted.
  assign w_sum_next = r_sum + SUM_W'(bus.bit_in) - SUM_W'(w_oldest);
  assign w_wrap     = bus.en && (r_cnt == CNT_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (w_clear) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred when a case arm does not assign.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.en) w_state_next = FILL;
      FILL:    if (w_wrap) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: history, running sum, frame counter and frame snapshot.
  // NOTE: the history is reset on purpose: its tail supplies the "oldest"
  // bit, which must read as zero while the window is filling.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_hist       <= '0;
      r_sum        <= '0;
      r_cnt        <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_sum  <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (bus.en) begin
        r_hist  <= {r_hist[N-2:0], bus.bit_in};
        r_sum   <= w_sum_next;
        r_cnt   <= r_cnt + 1'b1;  // wraps N-1 -> 0 naturally
        r_valid <= (w_state_next == RUN);
        if (w_wrap) begin
          r_frame_done <= 1'b1;
          r_frame_sum  <= w_sum_next;
        end
      end
    end
  end

  assign bus.sum_out    = r_sum;
  assign bus.sum_valid  = r_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_sum  = r_frame_sum;

endmodule

// File: tb/tb_prs_density_meter.sv
// -----------------------------------------------------------------------------
// tb_prs_density_meter
//   Self-checking bench for prs_density_meter with WIN_LOG2 = 5 (N = 32).
//   A short vector table, directed sequences for the window corner cases,
//   an 8-bit PRS-driven run and a randomized run, all compared against a
//   queue-based reference of the last N accepted bits.
// -----------------------------------------------------------------------------
module tb_prs_density_meter;

  localparam int WIN_LOG2 = 5;
  localparam int N        = 1 << WIN_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  prs_density_meter_if #(.WIN_LOG2(WIN_LOG2)) bus ();

  prs_density_meter #(.WIN_LOG2(WIN_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_win[$];     // last accepted bits, at most N
  int m_accepted;   // samples accepted since last clear
  int m_fsum;
  bit m_fd;

  function automatic int m_popcount();
    int s = 0;
    foreach (m_win[i]) s += m_win[i];
    return s;
  endfunction

  function automatic void model_update(input bit e, input bit c, input bit r, input bit b);
    if (r || c) begin
      m_win.delete();
      m_accepted = 0;
      m_fsum     = 0;
      m_fd       = 0;
    end else begin
      m_fd = 0;
      if (e) begin
        m_win.push_back(b);
        if (m_win.size() > N) void'(m_win.pop_front());
        m_accepted++;
        if (m_accepted % N == 0) begin
          m_fd   = 1;
          m_fsum = m_popcount();
        end
      end
    end
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".sum_out"},    int'(bus.sum_out),    m_popcount());
    check({tag, ".sum_valid"},  int'(bus.sum_valid),  int'(m_accepted >= N));
    check({tag, ".frame_done"}, int'(bus.frame_done), int'(m_fd));
    check({tag, ".frame_sum"},  int'(bus.frame_sum),  m_fsum);
  endtask

  // Apply one cycle of inputs, advance the model, compare just after the edge.
  task automatic step(input bit e, input bit c, input bit r, input bit b, input string tag);
    bus.en = e; bus.clr = c; rst = r; bus.bit_in = b;
    @(posedge clk);
    #1;
    model_update(e, c, r, b);
    check_model(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit en;
    bit clr;
    bit bit_in;
    int sum;
    bit valid;
    bit fd;
    int fsum;
  } vec_t;

  vec_t vecs[8];

  // 8-bit maximal-length PRS generator, x^8+x^6+x^5+x^4+1
  logic [7:0] lfsr;
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  initial begin
    int fd_count;
    int acc;
    bit b;

    vecs[0] = '{en:1, clr:0, bit_in:1, sum:1, valid:0, fd:0, fsum:0};
    vecs[1] = '{en:0, clr:0, bit_in:1, sum:1, valid:0, fd:0, fsum:0};
    vecs[2] = '{en:1, clr:0, bit_in:0, sum:1, valid:0, fd:0, fsum:0};
    vecs[3] = '{en:1, clr:0, bit_in:1, sum:2, valid:0, fd:0, fsum:0};
    vecs[4] = '{en:1, clr:1, bit_in:1, sum:0, valid:0, fd:0, fsum:0};
    vecs[5] = '{en:1, clr:0, bit_in:1, sum:1, valid:0, fd:0, fsum:0};
    vecs[6] = '{en:0, clr:0, bit_in:0, sum:1, valid:0, fd:0, fsum:0};
    vecs[7] = '{en:0, clr:1, bit_in:0, sum:0, valid:0, fd:0, fsum:0};

    bus.en = 0; bus.clr = 0; bus.bit_in = 0;

    // Reset state
    step(0, 0, 1, 0, "reset");
    step(0, 0, 1, 0, "reset2");

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      bus.en = vecs[i].en; bus.clr = vecs[i].clr; rst = 0; bus.bit_in = vecs[i].bit_in;
      @(posedge clk);
      #1;
      model_update(vecs[i].en, vecs[i].clr, 1'b0, vecs[i].bit_in);
      check($sformatf("vec%0d.sum", i),   int'(bus.sum_out),    vecs[i].sum);
      check($sformatf("vec%0d.valid", i), int'(bus.sum_valid),  int'(vecs[i].valid));
      check($sformatf("vec%0d.fd", i),    int'(bus.frame_done), int'(vecs[i].fd));
      check($sformatf("vec%0d.fsum", i),  int'(bus.frame_sum),  vecs[i].fsum);
    end

    // Ramp up: 32 ones
    step(0, 0, 1, 0, "rst_ramp");
    for (int i = 1; i <= N; i++) begin
      step(1, 0, 0, 1, "ramp_up");
      check("ramp_up.explicit_sum", int'(bus.sum_out), i);
    end
    check("ramp_up.valid_at_32", int'(bus.sum_valid),  1);
    check("ramp_up.fd_at_32",    int'(bus.frame_done), 1);
    check("ramp_up.fsum_32",     int'(bus.frame_sum),  N);

    // Ramp down: 32 zeros
    for (int i = 1; i <= N; i++) begin
      step(1, 0, 0, 0, "ramp_down");
      check("ramp_down.explicit_sum", int'(bus.sum_out), N - i);
      if (i < N) check("ramp_down.no_fd", int'(bus.frame_done), 0);
    end
    check("ramp_down.fd_at_64",  int'(bus.frame_done), 1);
    check("ramp_down.fsum_0",    int'(bus.frame_sum),  0);
    step(0, 0, 0, 1, "idle_after_frame");
    check("idle_after_frame.fd_low", int'(bus.frame_done), 0);

    // Alternating bits with en toggling
    step(0, 0, 1, 0, "rst_alt");
    fd_count = 0;
    acc = 0;
    for (int i = 0; i < 2 * N; i++) begin
      if (i % 2 == 0) begin
        step(1, 0, 0, (acc % 2 == 0), "alt_en");
        acc++;
      end else begin
        step(0, 0, 0, ~(acc % 2 == 0), "alt_hold");
      end
      if (bus.frame_done) fd_count++;
    end
    check("alt.sum_16",   int'(bus.sum_out),   N / 2);
    check("alt.valid",    int'(bus.sum_valid), 1);
    check("alt.fd_once",  fd_count,            1);

    // clr on the 20th sample of FILL
    step(0, 0, 1, 0, "rst_clr");
    for (int i = 1; i < 20; i++) step(1, 0, 0, 1, "clr_fill");
    step(1, 1, 0, 1, "clr_20th");
    check("clr_20th.sum_zero",  int'(bus.sum_out),   0);
    check("clr_20th.fsum_zero", int'(bus.frame_sum), 0);
    for (int i = 1; i <= N; i++) begin
      step(1, 0, 0, 1, "after_clr");
      check("after_clr.valid", int'(bus.sum_valid), int'(i == N));
    end

    // rst in RUN with sum 17
    step(0, 0, 1, 0, "rst_17");
    for (int i = 0; i < N; i++) step(1, 0, 0, (i < 17), "fill_17");
    check("run17.sum", int'(bus.sum_out), 17);
    step(1, 0, 1, 1, "rst_in_run");
    check("rst_in_run.sum",   int'(bus.sum_out),   0);
    check("rst_in_run.valid", int'(bus.sum_valid), 0);
    check("rst_in_run.fsum",  int'(bus.frame_sum), 0);

    // PRS-driven run, 255*32 samples
    step(0, 0, 1, 0, "rst_prs");
    lfsr = 8'h01;
    fd_count = 0;
    for (int i = 0; i < 255 * N; i++) begin
      lfsr = lfsr_next(lfsr);
      step(1, 0, 0, lfsr[0], "prs");
      if (bus.frame_done) fd_count++;
    end
    check("prs.frame_count", fd_count, 255);

    // Randomized en / clr / bit_in
    for (int i = 0; i < 3000; i++) begin
      b = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0), 1'b0, b, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
